// File: rtl/hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : hpm_counter_bank
// Brief    : Event-selectable hardware performance counters with CSR access,
//            sticky overflow status and a registered overflow interrupt.
//            Optional HPM_SNAPSHOT_EN adds snapshot_i and shadow regs at 0xB80+i.
// Revision : 1.0 - initial release
// ============================================================================
module hpm_counter_bank #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_COUNTERS = 8,
  parameter int NUM_EVENTS   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_EVENTS-1:0]   event_i,
`ifdef HPM_SNAPSHOT_EN
  input  logic                    snapshot_i,
`endif
  input  logic                    csr_valid,
  input  logic                    csr_write,
  input  logic [11:0]             csr_addr,
  input  logic [DATA_WIDTH-1:0]   csr_wdata,
  output logic                    csr_rvalid,
  output logic [DATA_WIDTH-1:0]   csr_rdata,
  output logic                    csr_err,
  output logic                    overflow_irq
);

  localparam int SELW = $clog2(NUM_EVENTS + 1);
  localparam int NSEL = 1 << SELW;

  localparam logic [11:0] c_CNT_BASE   = 12'hB00;
  localparam logic [11:0] c_SEL_BASE   = 12'h7C0;
  localparam logic [11:0] c_INHIBIT    = 12'h7D0;
  localparam logic [11:0] c_OVF_STATUS = 12'h7D1;
  localparam logic [11:0] c_OVF_ENABLE = 12'h7D2;
`ifdef HPM_SNAPSHOT_EN
  localparam logic [11:0] c_SHD_BASE   = 12'hB80;
`endif

  logic [DATA_WIDTH-1:0]   r_cnt [NUM_COUNTERS];
  logic [SELW-1:0]         r_sel [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] r_inhibit;
  logic [NUM_COUNTERS-1:0] r_ovf_status;
  logic [NUM_COUNTERS-1:0] r_ovf_enable;
  logic                    r_irq;
  logic                    r_rvalid;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [NSEL-1:0]         w_evt_pad;
  logic [NUM_COUNTERS-1:0] w_inc;
  logic [NUM_COUNTERS-1:0] w_wrap;
  logic [NUM_COUNTERS-1:0] w_cnt_hit;
  logic [NUM_COUNTERS-1:0] w_sel_hit;
  logic [NUM_COUNTERS-1:0] w_cnt_we;
  logic [NUM_COUNTERS-1:0] w_w1c;
  logic [NUM_COUNTERS-1:0] w_ovf_status_nxt;
  logic                    w_inh_hit;
  logic                    w_sts_hit;
  logic                    w_ena_hit;
  logic                    w_hit;
  logic                    w_ro;
  logic                    w_wr_ok;
  logic [DATA_WIDTH-1:0]   w_rd_value;
`ifdef HPM_SNAPSHOT_EN
  logic [DATA_WIDTH-1:0]   r_shadow [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] w_shd_hit;
`endif

  // Selector value indexes this padded vector directly: slot 0 and every
  // slot above NUM_EVENTS stay zero, so those selections never count.
  always_comb begin
    w_evt_pad                 = '0;
    w_evt_pad[NUM_EVENTS:1]   = event_i;
  end

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ctr
    assign w_inc[i]  = ~r_inhibit[i] & w_evt_pad[r_sel[i]];
    // A CSR write on the same edge replaces the increment, so no wrap occurs.
    assign w_wrap[i] = w_inc[i] & ~w_cnt_we[i] & (&r_cnt[i]);
  end

  always_comb begin
    w_cnt_hit  = '0;
    w_sel_hit  = '0;
    w_rd_value = '0;
`ifdef HPM_SNAPSHOT_EN
    w_shd_hit  = '0;
`endif
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_addr == c_CNT_BASE + 12'(i)) begin
        w_cnt_hit[i] = 1'b1;
        w_rd_value   = r_cnt[i];
      end
      if (csr_addr == c_SEL_BASE + 12'(i)) begin
        w_sel_hit[i]           = 1'b1;
        w_rd_value[SELW-1:0]   = r_sel[i];
      end
`ifdef HPM_SNAPSHOT_EN
      if (csr_addr == c_SHD_BASE + 12'(i)) begin
        w_shd_hit[i] = 1'b1;
        w_rd_value   = r_shadow[i];
      end
`endif
    end
    w_inh_hit = (csr_addr == c_INHIBIT);
    w_sts_hit = (csr_addr == c_OVF_STATUS);
    w_ena_hit = (csr_addr == c_OVF_ENABLE);
    if (w_inh_hit) w_rd_value[NUM_COUNTERS-1:0] = r_inhibit;
    if (w_sts_hit) w_rd_value[NUM_COUNTERS-1:0] = r_ovf_status;
    if (w_ena_hit) w_rd_value[NUM_COUNTERS-1:0] = r_ovf_enable;
  end

`ifdef HPM_SNAPSHOT_EN
  assign w_ro  = |w_shd_hit;
  assign w_hit = (|w_cnt_hit) | (|w_sel_hit) | (|w_shd_hit) | w_inh_hit | w_sts_hit | w_ena_hit;
`else
  assign w_ro  = 1'b0;
  assign w_hit = (|w_cnt_hit) | (|w_sel_hit) | w_inh_hit | w_sts_hit | w_ena_hit;
`endif

  assign w_wr_ok  = csr_valid & csr_write & w_hit & ~w_ro;
  assign w_cnt_we = w_cnt_hit & {NUM_COUNTERS{w_wr_ok}};
  assign w_w1c    = (w_wr_ok & w_sts_hit) ? csr_wdata[NUM_COUNTERS-1:0] : '0;
  // Hardware set is ORed in after the W1C clear so a same-edge set wins.
  assign w_ovf_status_nxt = (r_ovf_status & ~w_w1c) | w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_cnt[i] <= '0;
        r_sel[i] <= '0;
      end
      r_inhibit    <= '0;
      r_ovf_status <= '0;
      r_ovf_enable <= '0;
      r_irq        <= 1'b0;
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (w_cnt_we[i])
          r_cnt[i] <= csr_wdata;
        else if (w_inc[i])
          r_cnt[i] <= r_cnt[i] + DATA_WIDTH'(1);
        if (w_wr_ok && w_sel_hit[i])
          r_sel[i] <= csr_wdata[SELW-1:0];
      end
      if (w_wr_ok && w_inh_hit) r_inhibit    <= csr_wdata[NUM_COUNTERS-1:0];
      if (w_wr_ok && w_ena_hit) r_ovf_enable <= csr_wdata[NUM_COUNTERS-1:0];
      r_ovf_status <= w_ovf_status_nxt;
      r_irq        <= |(r_ovf_status & r_ovf_enable);
      r_rvalid     <= csr_valid & ~csr_write;
      r_err        <= csr_valid & (~w_hit | (csr_write & w_ro));
      r_rdata      <= (csr_valid && !csr_write) ? w_rd_value : '0;
    end
  end

`ifdef HPM_SNAPSHOT_EN
  // Copies the pre-increment values of every counter on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) r_shadow[i] <= '0;
    end else if (snapshot_i) begin
      for (int i = 0; i < NUM_COUNTERS; i++) r_shadow[i] <= r_cnt[i];
    end
  end
`endif

  assign csr_rvalid   = r_rvalid;
  assign csr_rdata    = r_rdata;
  assign csr_err      = r_err;
  assign overflow_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpm_counter_bank
// Brief    : Self-checking bench for hpm_counter_bank (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpm_counter_bank;

  localparam int DW = 64;
  localparam int NC = 8;
  localparam int NE = 16;
`ifdef HPM_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] event_i = '0;
`ifdef HPM_SNAPSHOT_EN
  logic          snapshot_i = 1'b0;
`endif
  logic          csr_valid = 1'b0;
  logic          csr_write = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic [DW-1:0] csr_wdata = '0;
  logic          csr_rvalid;
  logic [DW-1:0] csr_rdata;
  logic          csr_err;
  logic          overflow_irq;

  always #5 clk = ~clk;

  hpm_counter_bank #(
    .DATA_WIDTH  (DW),
    .NUM_COUNTERS(NC),
    .NUM_EVENTS  (NE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_i     (event_i),
`ifdef HPM_SNAPSHOT_EN
    .snapshot_i  (snapshot_i),
`endif
    .csr_valid   (csr_valid),
    .csr_write   (csr_write),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rvalid  (csr_rvalid),
    .csr_rdata   (csr_rdata),
    .csr_err     (csr_err),
    .overflow_irq(overflow_irq)
  );

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        rvalid;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic        got_rvalid;
  logic        got_err;
  logic [63:0] got_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; response is sampled just after the following edge.
  task automatic csr(input logic wr, input logic [11:0] addr, input logic [63:0] wd);
    csr_valid = 1'b1;
    csr_write = wr;
    csr_addr  = addr;
    csr_wdata = wd;
    tick();
    csr_valid = 1'b0;
    csr_write = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    got_rvalid = csr_rvalid;
    got_err    = csr_err;
    got_rdata  = csr_rdata;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [63:0] exp);
    csr(1'b0, addr, 64'h0);
    chk($sformatf("%s rdata", name), got_rdata, exp);
    chk($sformatf("%s rvalid", name), got_rvalid, 1);
    chk($sformatf("%s err", name), got_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 12'hB00, 64'h0,                   1'b1, 64'h0,                   1'b0};
    vecs[1]  = '{1'b1, 12'h7C0, 64'h3F,                  1'b0, 64'h0,                   1'b0};
    vecs[2]  = '{1'b0, 12'h7C0, 64'h0,                   1'b1, 64'h1F,                  1'b0};
    vecs[3]  = '{1'b1, 12'h7D0, 64'hFFFF,                1'b0, 64'h0,                   1'b0};
    vecs[4]  = '{1'b0, 12'h7D0, 64'h0,                   1'b1, 64'hFF,                  1'b0};
    vecs[5]  = '{1'b1, 12'h7D0, 64'h0,                   1'b0, 64'h0,                   1'b0};
    vecs[6]  = '{1'b1, 12'h7D2, 64'h1_0003,              1'b0, 64'h0,                   1'b0};
    vecs[7]  = '{1'b0, 12'h7D2, 64'h0,                   1'b1, 64'h3,                   1'b0};
    vecs[8]  = '{1'b1, 12'hB03, 64'hDEADBEEF_12345678,   1'b0, 64'h0,                   1'b0};
    vecs[9]  = '{1'b0, 12'hB03, 64'h0,                   1'b1, 64'hDEADBEEF_12345678,   1'b0};
    vecs[10] = '{1'b0, 12'h123, 64'h0,                   1'b1, 64'h0,                   1'b1};
    vecs[11] = '{1'b1, 12'h123, 64'h5,                   1'b0, 64'h0,                   1'b1};
    vecs[12] = '{1'b0, 12'hB08, 64'h0,                   1'b1, 64'h0,                   1'b1};
    vecs[13] = '{1'b0, 12'h7C8, 64'h0,                   1'b1, 64'h0,                   1'b1};
    vecs[14] = '{1'b0, 12'h7D3, 64'h0,                   1'b1, 64'h0,                   1'b1};
    vecs[15] = '{1'b0, 12'hB80, 64'h0,                   1'b1, 64'h0,                   !SNAP};
    vecs[16] = '{1'b0, 12'h7D1, 64'h0,                   1'b1, 64'h0,                   1'b0};
    vecs[17] = '{1'b1, 12'h7C0, 64'h0,                   1'b0, 64'h0,                   1'b0};
    vecs[18] = '{1'b0, 12'hB03, 64'h0,                   1'b1, 64'hDEADBEEF_12345678,   1'b0};
    vecs[19] = '{1'b0, 12'h7C0, 64'h0,                   1'b1, 64'h0,                   1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rvalid", csr_rvalid, 0);
    chk("reset err", csr_err, 0);
    chk("reset rdata", csr_rdata, 0);
    chk("reset irq", overflow_irq, 0);
    rst_n = 1'b1;
    tick();

    // Register map vectors
    for (int i = 0; i < NV; i++) begin
      csr(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d rvalid", i), got_rvalid, vecs[i].rvalid);
      chk($sformatf("vec%0d rdata", i), got_rdata, vecs[i].rdata);
      chk($sformatf("vec%0d err", i), got_err, vecs[i].err);
    end
    tick();
    chk("idle rvalid", csr_rvalid, 0);
    chk("idle err", csr_err, 0);
    chk("idle rdata", csr_rdata, 0);

    // Ten cycles of event 0 on counter 0
    csr(1'b1, 12'h7C0, 64'h1);
    event_i = 16'h0001;
    repeat (10) tick();
    event_i = '0;
    chk("cnt10 pre rvalid", csr_rvalid, 0);
    rd_chk("cnt10", 12'hB00, 64'd10);
    tick();
    chk("cnt10 pulse rvalid", csr_rvalid, 0);
    chk("cnt10 pulse rdata", csr_rdata, 0);

    // Write while counting: write wins, then counting resumes
    event_i = 16'h0001;
    csr(1'b1, 12'hB00, 64'h100);
    rd_chk("wr_cnt first", 12'hB00, 64'h100);
    rd_chk("wr_cnt next", 12'hB00, 64'h101);
    event_i = '0;

    // Inhibit
    csr(1'b1, 12'h7C2, 64'h3);
    csr(1'b1, 12'h7D0, 64'h4);
    event_i = 16'h0004;
    repeat (5) tick();
    event_i = '0;
    rd_chk("inhibited", 12'hB02, 64'd0);
    csr(1'b1, 12'h7D0, 64'h0);
    event_i = 16'h0004;
    repeat (5) tick();
    event_i = '0;
    rd_chk("uninhibited", 12'hB02, 64'd5);

    // Selector range edges
    csr(1'b1, 12'h7C4, 64'd17);
    csr(1'b1, 12'h7C5, 64'd16);
    event_i = '1;
    repeat (3) tick();
    event_i = '0;
    rd_chk("sel17 nocount", 12'hB04, 64'd0);
    rd_chk("sel16 count", 12'hB05, 64'd3);
    rd_chk("sel17 stored", 12'h7C4, 64'd17);

    // Overflow, irq, W1C
    csr(1'b1, 12'hB01, '1);
    csr(1'b1, 12'h7C1, 64'h2);
    csr(1'b1, 12'h7D2, 64'h2);
    event_i = 16'h0002;
    tick();
    event_i = '0;
    rd_chk("wrap cnt1", 12'hB01, 64'd0);
    chk("ovf irq set", overflow_irq, 1);
    rd_chk("ovf status", 12'h7D1, 64'h2);
    repeat (3) tick();
    rd_chk("ovf sticky", 12'h7D1, 64'h2);
    chk("ovf irq held", overflow_irq, 1);
    csr(1'b1, 12'h7D1, 64'h2);
    tick();
    chk("ovf irq clear", overflow_irq, 0);
    rd_chk("ovf cleared", 12'h7D1, 64'h0);

    // Write and increment on same edge: no overflow
    event_i = 16'h0002;
    csr(1'b1, 12'hB01, '1);
    event_i = '0;
    rd_chk("wr_vs_inc cnt", 12'hB01, '1);
    rd_chk("wr_vs_inc status", 12'h7D1, 64'h0);

    // Hardware set beats W1C on same edge
    event_i = 16'h0002;
    csr(1'b1, 12'h7D1, 64'h2);
    event_i = '0;
    rd_chk("set_wins status", 12'h7D1, 64'h2);
    rd_chk("set_wins cnt", 12'hB01, 64'h0);
    csr(1'b1, 12'h7D1, 64'h2);
    rd_chk("set_wins cleared", 12'h7D1, 64'h0);

`ifdef HPM_SNAPSHOT_EN
    csr(1'b1, 12'hB00, 64'd7);
    event_i    = 16'h0001;
    snapshot_i = 1'b1;
    tick();
    snapshot_i = 1'b0;
    rd_chk("snap shadow", 12'hB80, 64'd7);
    rd_chk("snap live", 12'hB00, 64'd9);
    csr(1'b1, 12'hB80, 64'h5);
    chk("snap wr err", got_err, 1);
    rd_chk("snap keep", 12'hB80, 64'd7);
    event_i = '0;
`endif

    // Asynchronous reset with a request in flight
    csr(1'b1, 12'hB01, '1);
    event_i = 16'h0002;
    tick();
    event_i = '0;
    tick();
    chk("pre-rst irq", overflow_irq, 1);
    csr_valid = 1'b1;
    csr_write = 1'b0;
    csr_addr  = 12'hB03;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst irq", overflow_irq, 0);
    chk("async rst rvalid", csr_rvalid, 0);
    tick();
    csr_valid = 1'b0;
    csr_addr  = '0;
    chk("rst edge rvalid", csr_rvalid, 0);
    rst_n = 1'b1;
    tick();
    chk("post rst rvalid", csr_rvalid, 0);
    chk("post rst err", csr_err, 0);
    rd_chk("post rst cnt3", 12'hB03, 64'h0);
    rd_chk("post rst enable", 12'h7D2, 64'h0);
    rd_chk("post rst sel0", 12'h7C0, 64'h0);
    rd_chk("post rst status", 12'h7D1, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpm_counter_bank.md
HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, counter and CSR data width.
REQ-002 SHALL have parameter NUM_COUNTERS, default 8, counter channels (1..16).
REQ-003 SHALL have parameter NUM_EVENTS, default 16, event input lines (1..31); SELW = $clog2(NUM_EVENTS+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 event_i  input  NUM_EVENTS  per-cycle event strobes from core pipeline.
REQ-007 csr_valid  input  1  CSR access request.
REQ-008 csr_write  input  1  1 = write, 0 = read.
REQ-009 csr_addr  input  12  CSR address.
REQ-010 csr_wdata  input  DATA_WIDTH  write data.
REQ-011 csr_rvalid  output  1  read data valid, one-cycle pulse.
REQ-012 csr_rdata  output  DATA_WIDTH  read data.
REQ-013 csr_err  output  1  one-cycle pulse: unmapped address.
REQ-014 overflow_irq  output  1  OR of (ovf_status & ovf_enable).

Function
REQ-015 Address map: 0xB00+i counter i; 0x7C0+i selector i (SELW bits); 0x7D0 inhibit (NUM_COUNTERS bits); 0x7D1 ovf_status (W1C); 0x7D2 ovf_enable; i < NUM_COUNTERS.
REQ-016 Counter i increments by 1 per cycle when selector i = s, s in 1..NUM_EVENTS, event_i[s-1] = 1, inhibit[i] = 0.
REQ-017 Selector value 0 or > NUM_EVENTS SHALL never count; write stores value unmodified.
REQ-018 Counter at all-ones that increments SHALL wrap to 0 and set ovf_status[i] the same edge.
REQ-019 ovf_status bits sticky; cleared only by writing 1 to bit at 0x7D1 or reset.
REQ-020 Same-cycle hardware set and W1C clear of one ovf_status bit: set wins.
REQ-021 Same-cycle CSR write and increment on one counter: written value stored, increment dropped, no overflow flagged.
REQ-022 CSR accepted every cycle csr_valid = 1; no backpressure.
REQ-023 Read: csr_rvalid = 1 and csr_rdata = register value sampled at request edge, exactly 1 cycle after request.
REQ-024 Read data zero-extended to DATA_WIDTH; unused bits of narrow registers read 0.
REQ-025 Write takes effect at request edge; read of same address next cycle returns new value.
REQ-026 Write upper bits beyond register width ignored.
REQ-027 Unmapped address read or write: csr_err = 1 one cycle after request; read also asserts csr_rvalid with csr_rdata = 0; no state change.
REQ-028 csr_rvalid, csr_err, csr_rdata SHALL be 0 in every cycle without a completing read/error.
REQ-029 overflow_irq registered: asserted the cycle after the ovf_status/ovf_enable update causing it.

Reset
REQ-030 rst_n low SHALL immediately clear: counters, selectors, inhibit, ovf_status, ovf_enable, snapshot registers, csr_rvalid, csr_rdata, csr_err, overflow_irq to 0.
REQ-031 Request in cycle where reset asserts SHALL be discarded; no response after deassertion.
REQ-032 First counting edge is first rising edge with rst_n high.

Configuration
REQ-033 Macro HPM_SNAPSHOT_EN defined: extra input snapshot_i (1 bit); on edge with snapshot_i = 1 all counters copied atomically (pre-increment values) into shadow registers, readable at 0xB80+i, read-only (writes raise csr_err).
REQ-034 HPM_SNAPSHOT_EN undefined: no snapshot_i port, no shadow storage; 0xB80+i unmapped per REQ-027.

Verification
REQ-035 Reset, write selector0=1, hold event_i[0]=1 10 cycles, read 0xB00 -> rdata 10, rvalid exactly 1 cycle after request.
REQ-036 Write counter1 = all-ones, selector1=2, ovf_enable=0x2, pulse event_i[1] once -> counter1 = 0, ovf_status = 0x2, overflow_irq = 1 next cycle; write 0x2 to 0x7D1 -> irq 0.
REQ-037 Selector2=3, inhibit=0x4, event_i[2]=1 5 cycles -> counter2 0; clear inhibit, 5 cycles -> 5.
REQ-038 Counter0 counting each cycle, write 0x100 to 0xB00 -> read next cycle 0x100; following cycle 0x101.
REQ-039 Read 0x123 -> csr_rvalid=1, csr_rdata=0, csr_err=1 one cycle later; no register changes.
REQ-040 HPM_SNAPSHOT_EN: counter0 = 7 counting, pulse snapshot_i -> 0xB80 reads 7 while 0xB00 keeps advancing; write 0xB80 -> csr_err=1.
